// File: rtl/demux1_8_stream_if.sv
// ============================================================================
// Module      : demux1_8_stream_if
// Description : Producer-side and consumer-side handshake bundle for the
//               1-to-8 stream demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux1_8_stream_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   in_data;
    logic [2:0]         in_sel;
    logic               in_bcast;
    logic               in_valid;
    logic               in_ready;
    logic [8*WIDTH-1:0] out_data;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready;
    logic               busy;

    // Environment view: drives the producer side and the consumer readies.
    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    // Demultiplexer view.
    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/demux1_8_stream.sv
// ============================================================================
// Module      : demux1_8_stream
// Description : Registered 1-to-8 stream demultiplexer with per-channel
//               one-entry holding registers, unicast or broadcast steering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1_8_stream #(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    demux1_8_stream_if.slave  bus
);

    localparam int C_NCH = 8;

    logic [C_NCH-1:0][WIDTH-1:0] r_data;
    logic [C_NCH-1:0]            r_valid;

    logic [C_NCH-1:0] w_free;
    logic [C_NCH-1:0] w_wr;
    logic             w_in_ready;
    logic             w_accept;

    // A channel can take a word if it is empty or its consumer drains it now.
    assign w_free     = ~r_valid | bus.out_ready;
    assign w_in_ready = bus.in_bcast ? (&w_free) : w_free[bus.in_sel];
    assign w_accept   = bus.in_valid & w_in_ready;

    always_comb begin
        w_wr = '0;
        if (w_accept) begin
            if (bus.in_bcast) begin
                w_wr = {C_NCH{1'b1}};
            end else begin
                w_wr = C_NCH'(1) << bus.in_sel;
            end
        end
    end

    // A write wins over a drain, so a drained-and-refilled channel has no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int i = 0; i < C_NCH; i++) begin
                if (w_wr[i]) begin
                    r_data[i]  <= bus.in_data;
                    r_valid[i] <= 1'b1;
                end else if (bus.out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.busy      = |r_valid;

endmodule

`default_nettype wire

// File: doc/demux1_8_stream.md
# demux1_8_stream

Registered 1-to-8 stream demultiplexer with a valid/ready handshake on every port: the write-side counterpart of the 8:1 select muxes in the datapath. Each word arrives with a 3-bit destination select, or a broadcast flag, and is steered into a one-entry holding register on the selected output channel(s). The block sits between a single producer (e.g. a writeback/result bus) and up to eight independent consumers that may stall individually.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (≥1)

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  word to route
- in_sel  input  3  destination channel 0–7; ignored when in_bcast=1
- in_bcast  input  1  1 = write word to all 8 channels
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts word this cycle (combinational)
- out_data  output  8*WIDTH  channel i data at bits [i*WIDTH +: WIDTH], registered
- out_valid  output  8  channel i holds a word, registered
- out_ready  input  8  consumer i takes word this cycle
- busy  output  1  OR of out_valid, registered-derived

## Operation
- Per channel i: holding register data_q[i] (WIDTH) and flag valid_q[i]; out_data/out_valid drive these directly.
- free[i] = !valid_q[i] || out_ready[i] (empty, or draining this cycle).
- in_ready = in_bcast ? (all free[0..7]) : free[in_sel]. in_ready does not depend on in_valid.
- Accept = in_valid && in_ready.
- Unicast accept: data_q[in_sel] <= in_data, valid_q[in_sel] <= 1. Other channels untouched.
- Broadcast accept: all data_q[i] <= in_data, all valid_q[i] <= 1. Broadcast is all-or-nothing; no partial writes.
- Drain: valid_q[i] && out_ready[i] clears valid_q[i] unless the same channel is written in the same cycle. Simultaneous drain + write leaves valid_q[i]=1 with the new data (no bubble).
- out_ready[i] with valid_q[i]=0 has no effect.
- data_q[i] is unchanged when not written; consumers see stable data while out_valid[i]=1 and out_ready[i]=0.
- Words are never dropped or duplicated: each accepted unicast word appears exactly once on its channel; each broadcast word appears exactly once on every channel.
- busy = |valid_q.

## Timing
- Reset (reset_n=0, asynchronous assert, takes effect immediately): valid_q=0, data_q=0, so out_valid=8'h00, out_data=0, busy=0. in_ready is combinational: it reflects free[] and is 1 under reset.
- Reset mid-operation discards all held words with no drain. Deassertion is sampled synchronously; the first accept can occur on the first rising edge with reset_n=1.
- Latency: word accepted at edge N shows out_valid=1 immediately after edge N, so it is visible in cycle N+1.
- Throughput: 1 word/cycle into any channel whose consumer holds out_ready=1; back-to-back unicasts to different channels need no consumer activity until each target is occupied.
- Stall: a full channel with out_ready=0 blocks only inputs addressed to it (and all broadcasts). It does not block other unicast channels.
- Combinational path out_ready → in_ready exists by design. The producer must not make in_valid depend on in_ready.
- Producer may change in_sel/in_data while in_valid=1 and in_ready=0; no ordering guarantee is implied across channels.

## Test plan
- Reset: hold reset_n=0 with in_valid=1, in_sel=3 → out_valid=8'h00, out_data=0, busy=0. Release; next edge accepts the word and out_valid=8'h08.
- Unicast sweep: out_ready=8'h00, send data 32'hA0+i to in_sel=i for i=0..7 on consecutive cycles → in_ready=1 each cycle, out_valid=8'hFF after 8 edges, channel i holds 32'hA0+i. A 9th word to sel=2 → in_ready=0, and channel 2 still holds 32'hA2.
- Stall isolation: channel 5 full with out_ready[5]=0; word 32'h55 to sel=5 → in_ready=0. Same cycle, switch to sel=1 (empty) → in_ready=1, and channel 1 receives it.
- Drain + refill: channel 0 holds 32'h11, out_ready[0]=1, in_valid=1, sel=0, data=32'h22 → accepted. out_valid[0] stays 1 and out_data ch0=32'h22 after the edge, with no idle cycle.
- Broadcast: channel 4 full with out_ready[4]=0, broadcast 32'hBEEF → in_ready=0 and no channel changes. Raise out_ready[4] → accepted, all 8 channels = 32'hBEEF, out_valid=8'hFF.
- Reset mid-stream: out_valid=8'h3C, assert reset_n=0 between edges → out_valid=8'h00 immediately without waiting for an edge. After release, no stale word reappears.
